// File: rtl/system_btn_ctrl.sv
// Avalon-MM push-button controller: sync, debounce, edge capture, masked IRQ.
// Define BTN_CTRL_AUTOREPEAT_EN to re-capture held buttons every REPEAT_CYCLES.
module system_btn_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned REPEAT_CYCLES   = 12500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    input  logic [3:0]  in_port,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam logic [3:0]  RELEASED = ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [23:0] DEB_LAST = 24'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync1_q, sync2_q, pressed;
    logic [3:0]       deb_q, deb_d;
    logic [3:0][23:0] dcnt_q, dcnt_d;
    logic [3:0]       ec_q, ec_d;
    logic [3:0]       mask_q, mask_d;
    logic [3:0]       rpt, w1c;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q, irq_d;
    logic             wr;
    logic             unused_wd;

    assign unused_wd = ^writedata[31:4];
    assign pressed   = sync2_q ^ {4{ACTIVE_LOW}};
    assign wr        = chipselect & ~write_n;

    always_comb begin
        deb_d  = deb_q;
        dcnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (pressed[i] != deb_q[i]) begin
                if (dcnt_q[i] == DEB_LAST) deb_d[i] = pressed[i];
                else dcnt_d[i] = dcnt_q[i] + 24'd1;
            end
        end
    end

`ifdef BTN_CTRL_AUTOREPEAT_EN
    localparam logic [23:0] RPT_LAST = 24'(REPEAT_CYCLES - 1);

    logic [3:0][23:0] rcnt_q, rcnt_d;

    // Counter phase starts at the press event, so repeats land on multiples of the period
    always_comb begin
        rpt    = '0;
        rcnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (deb_q[i]) begin
                if (rcnt_q[i] == RPT_LAST) rpt[i] = 1'b1;
                else rcnt_d[i] = rcnt_q[i] + 24'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rcnt_q <= '0;
        else rcnt_q <= rcnt_d;
    end
`else
    assign rpt = '0;
`endif

    always_comb begin
        w1c    = (wr && address == 2'd3) ? writedata[3:0] : 4'h0;
        mask_d = (wr && address == 2'd1) ? writedata[3:0] : mask_q;
        // New events are ORed last so they beat a same-cycle clear
        ec_d   = (ec_q & ~w1c) | (deb_d & ~deb_q) | rpt;
        irq_d  = |(ec_q & mask_q);
    end

    always_comb begin
        rdata_d = '0;
        if (chipselect) begin
            case (address)
                2'd0:    rdata_d[3:0] = deb_q;
                2'd1:    rdata_d[3:0] = mask_q;
                2'd3:    rdata_d[3:0] = ec_q;
                default: rdata_d      = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= RELEASED;
            sync2_q <= RELEASED;
            deb_q   <= '0;
            dcnt_q  <= '0;
            ec_q    <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            dcnt_q  <= dcnt_d;
            ec_q    <= ec_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = irq_q;

endmodule
